// File: rtl/dcache_controller_if.sv
// Bus bundle for dcache_controller: CPU load/store port, cache SRAM port and backing-memory port.
// Handshakes: CPU access completes in a cycle with cpu_req_i && !cpu_stall_o (request held until then);
// memory transfer completes in a cycle with mem_enable_o && mem_ack_i (enable, address, data held until then).
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;

  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_hit_i;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;

  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    output cpu_data_o, cpu_stall_o,
    output sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    input  sram_hit_i, sram_tag_i, sram_data_i,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_enable_o, sram_write_o, sram_addr_o, sram_tag_o, sram_data_o,
    output sram_hit_i, sram_tag_i, sram_data_i,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_controller.sv
// Sequencer for a 2-way, 16-set, 256-bit-line data cache: hit service, dirty write-back, refill.
// Optional hit/miss counters are enabled by defining DCACHE_CTRL_STATS_EN.
module dcache_controller (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dcache_controller_if.master  bus,
  output logic [2:0]           o_dbg_state
`ifdef DCACHE_CTRL_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MISS      = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_READMISS  = 3'd3,
    ST_REFILL    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [31:2]   r_addr;
  logic          r_write;
  logic [31:0]   r_data;
  logic [22:0]   r_vtag;
  logic [255:0]  r_vdata;

  logic [3:0]    w_index;
  logic [2:0]    w_word;
  logic [22:0]   w_tag;
  logic [3:0]    w_r_index;
  logic [2:0]    w_r_word;
  logic [22:0]   w_r_tag;
  logic          w_req_hit;
  logic          w_req_miss;
  logic          w_victim_dirty;
  logic          w_unused_addr;

  assign w_index        = bus.cpu_addr_i[8:5];
  assign w_word         = bus.cpu_addr_i[4:2];
  assign w_tag          = bus.cpu_addr_i[31:9];
  assign w_r_index      = r_addr[8:5];
  assign w_r_word       = r_addr[4:2];
  assign w_r_tag        = r_addr[31:9];
  assign w_req_hit      = bus.cpu_req_i && bus.sram_hit_i;
  assign w_req_miss     = bus.cpu_req_i && !bus.sram_hit_i;
  assign w_victim_dirty = bus.sram_tag_i[24] && bus.sram_tag_i[23];
  assign w_unused_addr  = ^bus.cpu_addr_i[1:0];
  assign o_dbg_state    = r_state;

  function automatic logic [255:0] f_merge(input logic [255:0] line,
                                           input logic [2:0]   word,
                                           input logic [31:0]  data);
    logic [255:0] res;
    res = line;
    res[{word, 5'b0} +: 32] = data;
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // The missed access is captured once so the sequence finishes even if the CPU drops its request.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_vtag  <= '0;
      r_vdata <= '0;
    end else begin
      if (r_state == ST_IDLE && w_req_miss) begin
        r_addr  <= bus.cpu_addr_i[31:2];
        r_write <= bus.cpu_write_i;
        r_data  <= bus.cpu_data_i;
      end
      if (r_state == ST_MISS) begin
        r_vtag  <= bus.sram_tag_i[22:0];
        r_vdata <= bus.sram_data_i;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (w_req_miss) w_next = ST_MISS;
      ST_MISS:      w_next = w_victim_dirty ? ST_WRITEBACK : ST_READMISS;
      ST_WRITEBACK: if (bus.mem_ack_i) w_next = ST_READMISS;
      ST_READMISS:  if (bus.mem_ack_i) w_next = ST_REFILL;
      ST_REFILL:    w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_data_o    = '0;
    bus.cpu_stall_o   = (r_state != ST_IDLE) || w_req_miss;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_addr_o   = w_r_index;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    bus.mem_enable_o  = 1'b0;
    bus.mem_write_o   = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;
    case (r_state)
      ST_IDLE: begin
        bus.sram_enable_o = bus.cpu_req_i;
        bus.sram_addr_o   = w_index;
        if (w_req_hit && !bus.cpu_write_i) begin
          bus.cpu_data_o = bus.sram_data_i[{w_word, 5'b0} +: 32];
        end
        if (w_req_hit && bus.cpu_write_i) begin
          bus.sram_write_o = 1'b1;
          bus.sram_data_o  = f_merge(bus.sram_data_i, w_word, bus.cpu_data_i);
          bus.sram_tag_o   = {2'b11, w_tag};
        end
      end
      ST_MISS: begin
        bus.sram_enable_o = 1'b1;
      end
      ST_WRITEBACK: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {r_vtag, w_r_index, 5'b0};
        bus.mem_data_o   = r_vdata;
      end
      ST_READMISS: begin
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {w_r_tag, w_r_index, 5'b0};
        if (bus.mem_ack_i) begin
          bus.sram_enable_o = 1'b1;
          bus.sram_write_o  = 1'b1;
          bus.sram_data_o   = r_write ? f_merge(bus.mem_data_i, w_r_word, r_data)
                                      : bus.mem_data_i;
          bus.sram_tag_o    = {1'b1, r_write, w_r_tag};
        end
      end
      default: ;
    endcase
  end

`ifdef DCACHE_CTRL_STATS_EN
  logic        r_replay;
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // r_replay marks the first IDLE cycle after a refill, whose hit is the replayed access.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_replay   <= 1'b0;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == ST_REFILL)    r_replay <= 1'b1;
      else if (r_state == ST_IDLE) r_replay <= 1'b0;
      if (r_state == ST_IDLE && w_req_hit && !r_replay) r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (r_state == ST_IDLE && w_req_miss)             r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
